// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receiver that fills the message RAM:
// FSM state encodings, the line-feed terminator and the bit-time helper.
package uart_rx_pkg;

  typedef logic [2:0] state_t;

  localparam state_t IDLE   = 3'd0;
  localparam state_t START  = 3'd1;
  localparam state_t DATA   = 3'd2;
  localparam state_t PARITY = 3'd3;
  localparam state_t STOP   = 3'd4;
  localparam state_t WRITE  = 3'd5;
  localparam state_t BREAK  = 3'd6;

  localparam logic [7:0] LINE_FEED = 8'h0A;

  // Number of clocks per serial bit.
  function automatic int bit_time(input int clock_frequency, input int baud_rate);
    return clock_frequency / baud_rate;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Loadable down-counter used to space the receiver's bit samples.
// Expired is high for exactly one cycle, LoadValue cycles after a load,
// so the FSM acts on the clock edge LoadValue cycles after loading.
module uart_bit_timer #(
  parameter int Width = 5
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Load,
  input  logic [Width-1:0] LoadValue,
  output logic             Expired
);

  logic [Width-1:0] count;

  // Count down to zero and park there until the next load.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      count <= '0;
    end else if (Load) begin
      count <= LoadValue;
    end else if (count != '0) begin
      count <= count - Width'(1);
    end
  end

  assign Expired = (count == Width'(1));

endmodule

// File: rtl/uart_rx_ram_writer.sv
// UART receiver that writes each received character into the 21x7 message
// RAM at an auto-incrementing address. A line feed ends the message and
// rewinds the address to 0.
// Optional feature: define UART_RX_PARITY_CHECK_EN for 8E1 frames with a
// ParityError pulse; the default build receives 8N1 frames.
module uart_rx_ram_writer
  import uart_rx_pkg::*;
#(
  parameter int ClockFrequency = 1600,
  parameter int BaudRate       = 100,
  parameter int DataLength     = 7,
  parameter int AddressBits    = 5,
  parameter int MemorySize     = 21
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic                   SerialIn,
  output logic                   ReadOrWrite,
  output logic [AddressBits-1:0] Address,
  output logic [DataLength-1:0]  InputValue,
  output logic                   MessageDone,
  output logic                   FramingError
`ifdef UART_RX_PARITY_CHECK_EN
  ,
  output logic                   ParityError
`endif
);

  localparam int BitTime    = bit_time(ClockFrequency, BaudRate);
  localparam int TimerWidth = $clog2(BitTime) + 1;

  localparam logic [TimerWidth-1:0]  FullBit     = TimerWidth'(BitTime);
  localparam logic [TimerWidth-1:0]  HalfBit     = TimerWidth'(BitTime / 2);
  localparam logic [AddressBits-1:0] LastAddress = AddressBits'(MemorySize - 1);

  logic sync_meta;
  logic rx;

  state_t state;
  state_t state_next;

  logic [2:0] bit_index;
  logic [7:0] shift_reg;
  logic [7:0] shifted;

  logic                  timer_load;
  logic [TimerWidth-1:0] timer_value;
  logic                  timer_expired;

  logic sample_bit;
  logic framing_hit;

`ifdef UART_RX_PARITY_CHECK_EN
  logic parity_sample;
  logic parity_bad;
  logic parity_mismatch;
`endif

  // Bring the asynchronous RX line into the clock domain.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      sync_meta <= 1'b1;
      rx        <= 1'b1;
    end else begin
      sync_meta <= SerialIn;
      rx        <= sync_meta;
    end
  end

  uart_bit_timer #(
    .Width(TimerWidth)
  ) u_bit_timer (
    .Clock    (Clock),
    .Reset    (Reset),
    .Load     (timer_load),
    .LoadValue(timer_value),
    .Expired  (timer_expired)
  );

  assign shifted = {rx, shift_reg[7:1]};

`ifdef UART_RX_PARITY_CHECK_EN
  assign parity_mismatch = (^shift_reg) ^ rx;
`endif

  // Frame sequencing: half-bit delay to the start-bit centre, then one
  // full bit per sample; the timer is reloaded on every timed transition.
  always_comb begin
    state_next  = state;
    timer_load  = 1'b0;
    timer_value = FullBit;
    sample_bit  = 1'b0;
    framing_hit = 1'b0;
`ifdef UART_RX_PARITY_CHECK_EN
    parity_sample = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (!rx) begin
          timer_load  = 1'b1;
          timer_value = HalfBit;
          state_next  = START;
        end
      end
      START: begin
        if (timer_expired) begin
          if (!rx) begin
            timer_load = 1'b1;
            state_next = DATA;
          end else begin
            state_next = IDLE;
          end
        end
      end
      DATA: begin
        if (timer_expired) begin
          sample_bit = 1'b1;
          timer_load = 1'b1;
          if (bit_index == 3'd7) begin
`ifdef UART_RX_PARITY_CHECK_EN
            state_next = PARITY;
`else
            state_next = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_CHECK_EN
      PARITY: begin
        if (timer_expired) begin
          parity_sample = 1'b1;
          timer_load    = 1'b1;
          state_next    = STOP;
        end
      end
`endif
      STOP: begin
        if (timer_expired) begin
          if (!rx) begin
            framing_hit = 1'b1;
            state_next  = BREAK;
`ifdef UART_RX_PARITY_CHECK_EN
          end else if (parity_bad) begin
            state_next = IDLE;
`endif
          end else begin
            state_next = WRITE;
          end
        end
      end
      WRITE: begin
        state_next = IDLE;
      end
      BREAK: begin
        if (rx) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register; reset abandons any frame in progress.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Deserialize LSB first and latch the character once bit 7 is in, so
  // InputValue is already stable through the stop bit and the write.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      bit_index  <= 3'd0;
      shift_reg  <= 8'h00;
      InputValue <= '0;
    end else begin
      if (state != DATA) begin
        bit_index <= 3'd0;
      end else if (sample_bit) begin
        bit_index <= bit_index + 3'd1;
      end
      if (sample_bit) begin
        shift_reg <= shifted;
        if (bit_index == 3'd7) begin
          InputValue <= shifted[DataLength-1:0];
        end
      end
    end
  end

  // Advance the write address after each write; a line feed rewinds it.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      Address <= '0;
    end else if (state == WRITE) begin
      if (shift_reg == LINE_FEED) begin
        Address <= '0;
      end else if (Address == LastAddress) begin
        Address <= '0;
      end else begin
        Address <= Address + AddressBits'(1);
      end
    end
  end

  // One-cycle error pulse for a stop bit sampled low.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      FramingError <= 1'b0;
    end else begin
      FramingError <= framing_hit;
    end
  end

`ifdef UART_RX_PARITY_CHECK_EN
  // Even-parity check; a mismatch suppresses the write and pulses once.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      parity_bad  <= 1'b0;
      ParityError <= 1'b0;
    end else begin
      ParityError <= parity_sample && parity_mismatch;
      if (parity_sample) begin
        parity_bad <= parity_mismatch;
      end
    end
  end
`endif

  assign ReadOrWrite = (state != WRITE);
  assign MessageDone = (state == WRITE) && (shift_reg == LINE_FEED);

endmodule

// File: tb/tb_uart_rx_ram_writer.sv
// Self-checking bench for uart_rx_ram_writer (8N1, BitTime = 16).
// A reference model predicts the address, value, line-feed flag and cycle
// of every RAM write from the frames sent; a monitor records what the DUT
// actually wrote.
module tb_uart_rx_ram_writer;

  localparam int BitTime      = 16;
  localparam int HalfBit      = BitTime / 2;
  localparam int MemorySize   = 21;
  localparam int WriteLatency = 2 + HalfBit + 9 * BitTime + 1;

  logic       clk;
  logic       rst_n;
  logic       serial_in;
  logic       read_or_write;
  logic [4:0] address;
  logic [6:0] input_value;
  logic       message_done;
  logic       framing_error;
`ifdef UART_RX_PARITY_CHECK_EN
  logic       parity_error;
`endif

  int passed = 0;
  int total  = 0;
  int cycle  = 0;

  int         wr_cycle[$];
  logic [4:0] wr_addr[$];
  logic [6:0] wr_val[$];
  logic       wr_done[$];
  int         fe_count = 0;
  int         stray_done = 0;

  int         exp_cycle[$];
  int         exp_addr[$];
  logic [6:0] exp_val[$];
  logic       exp_done[$];
  int         model_addr = 0;

  uart_rx_ram_writer #(
    .ClockFrequency(1600),
    .BaudRate      (100),
    .DataLength    (7),
    .AddressBits   (5),
    .MemorySize    (MemorySize)
  ) dut (
    .Clock       (clk),
    .Reset       (rst_n),
    .SerialIn    (serial_in),
    .ReadOrWrite (read_or_write),
    .Address     (address),
    .InputValue  (input_value),
    .MessageDone (message_done),
    .FramingError(framing_error)
`ifdef UART_RX_PARITY_CHECK_EN
    ,
    .ParityError (parity_error)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  // Record every RAM write and every error pulse, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (read_or_write === 1'b0) begin
        wr_cycle.push_back(cycle);
        wr_addr.push_back(address);
        wr_val.push_back(input_value);
        wr_done.push_back(message_done);
      end else if (message_done !== 1'b0) begin
        stray_done++;
      end
      if (framing_error === 1'b1) fe_count++;
    end
  end

  task automatic hold(input logic level, input int cycles);
    serial_in = level;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input int stop_low, output int start_cycle);
    start_cycle = cycle;
    hold(1'b0, BitTime);
    for (int i = 0; i < 8; i++) hold(b[i], BitTime);
    if (stop_low > 0) hold(1'b0, stop_low);
    hold(1'b1, BitTime);
  endtask

  // Reference model: a valid frame writes bits [6:0] at the current
  // address; a line feed restarts the message, otherwise the address
  // steps through 0..MemorySize-1 and wraps.
  task automatic model_frame(input logic [7:0] b, input int start_cycle);
    exp_cycle.push_back(start_cycle + WriteLatency);
    exp_addr.push_back(model_addr);
    exp_val.push_back(b[6:0]);
    exp_done.push_back(b == 8'h0A);
    if (b == 8'h0A) model_addr = 0;
    else model_addr = (model_addr + 1) % MemorySize;
  endtask

  task automatic clear_queues();
    wr_cycle.delete(); wr_addr.delete(); wr_val.delete(); wr_done.delete();
    exp_cycle.delete(); exp_addr.delete(); exp_val.delete(); exp_done.delete();
    fe_count = 0;
    stray_done = 0;
  endtask

  task automatic pulse_reset();
    serial_in = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_addr = 0;
    hold(1'b1, 4);
  endtask

  function automatic logic [7:0] rand_non_lf();
    logic [7:0] v;
    v = 8'($urandom_range(0, 255));
    if (v == 8'h0A) v = 8'h0B;
    return v;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    serial_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++; if (read_or_write !== 1'b1) $display("[TB] FAIL reset_rw got %b want 1", read_or_write); else passed++;
    total++; if (address !== 5'd0) $display("[TB] FAIL reset_addr got %0d want 0", address); else passed++;
    total++; if (input_value !== 7'd0) $display("[TB] FAIL reset_value got %h want 0", input_value); else passed++;
    total++; if (message_done !== 1'b0) $display("[TB] FAIL reset_done got %b want 0", message_done); else passed++;
    total++; if (framing_error !== 1'b0) $display("[TB] FAIL reset_fe got %b want 0", framing_error); else passed++;
    rst_n = 1'b1;
    model_addr = 0;
    hold(1'b1, 4);
  endtask

  task automatic test_single_char();
    int s;
    clear_queues();
    send_frame(8'h45, 0, s);
    model_frame(8'h45, s);
    hold(1'b1, 4);
    total++; if (wr_addr.size() !== 1) $display("[TB] FAIL single_count got %0d want 1", wr_addr.size()); else passed++;
    if (wr_addr.size() == 1) begin
      total++; if (wr_addr[0] !== 5'd0) $display("[TB] FAIL single_addr got %0d want 0", wr_addr[0]); else passed++;
      total++; if (wr_val[0] !== 7'h45) $display("[TB] FAIL single_value got %h want 45", wr_val[0]); else passed++;
      total++; if (wr_cycle[0] !== exp_cycle[0]) $display("[TB] FAIL single_latency got %0d want %0d", wr_cycle[0] - s, WriteLatency); else passed++;
      total++; if (wr_done[0] !== 1'b0) $display("[TB] FAIL single_done got %b want 0", wr_done[0]); else passed++;
    end
    total++; if (address !== 5'd1) $display("[TB] FAIL single_next_addr got %0d want 1", address); else passed++;
  endtask

  task automatic test_wrap();
    int s;
    logic [7:0] b;
    pulse_reset();
    clear_queues();
    for (int i = 0; i < MemorySize; i++) begin
      b = rand_non_lf();
      send_frame(b, 0, s);
      model_frame(b, s);
    end
    send_frame(8'h5A, 0, s);
    model_frame(8'h5A, s);
    hold(1'b1, 4);
    total++; if (wr_addr.size() !== exp_addr.size()) $display("[TB] FAIL wrap_count got %0d want %0d", wr_addr.size(), exp_addr.size()); else passed++;
    for (int i = 0; i < wr_addr.size() && i < exp_addr.size(); i++) begin
      total++; if (int'(wr_addr[i]) !== exp_addr[i]) $display("[TB] FAIL wrap_addr[%0d] got %0d want %0d", i, wr_addr[i], exp_addr[i]); else passed++;
      total++; if (wr_val[i] !== exp_val[i]) $display("[TB] FAIL wrap_value[%0d] got %h want %h", i, wr_val[i], exp_val[i]); else passed++;
      total++; if (wr_cycle[i] !== exp_cycle[i]) $display("[TB] FAIL wrap_cycle[%0d] got %0d want %0d", i, wr_cycle[i], exp_cycle[i]); else passed++;
    end
    total++; if (int'(address) !== model_addr) $display("[TB] FAIL wrap_next_addr got %0d want %0d", address, model_addr); else passed++;
  endtask

  task automatic test_line_feed();
    int s;
    pulse_reset();
    clear_queues();
    send_frame(8'h41, 0, s);
    model_frame(8'h41, s);
    send_frame(8'h0A, 0, s);
    model_frame(8'h0A, s);
    hold(1'b1, 4);
    total++; if (wr_addr.size() !== 2) $display("[TB] FAIL lf_count got %0d want 2", wr_addr.size()); else passed++;
    for (int i = 0; i < wr_addr.size() && i < 2; i++) begin
      total++; if (int'(wr_addr[i]) !== exp_addr[i]) $display("[TB] FAIL lf_addr[%0d] got %0d want %0d", i, wr_addr[i], exp_addr[i]); else passed++;
      total++; if (wr_done[i] !== exp_done[i]) $display("[TB] FAIL lf_done[%0d] got %b want %b", i, wr_done[i], exp_done[i]); else passed++;
      total++; if (wr_val[i] !== exp_val[i]) $display("[TB] FAIL lf_value[%0d] got %h want %h", i, wr_val[i], exp_val[i]); else passed++;
    end
    total++; if (address !== 5'd0) $display("[TB] FAIL lf_next_addr got %0d want 0", address); else passed++;
    total++; if (stray_done !== 0) $display("[TB] FAIL lf_stray_done got %0d want 0", stray_done); else passed++;
  endtask

  task automatic test_framing_error();
    int s;
    logic [7:0] b;
    logic [4:0] addr_before;
    clear_queues();
    b = rand_non_lf();
    send_frame(b, 0, s);
    model_frame(b, s);
    hold(1'b1, 4);
    addr_before = address;
    total++; if (int'(addr_before) !== model_addr) $display("[TB] FAIL fe_pre_addr got %0d want %0d", addr_before, model_addr); else passed++;
    send_frame(8'h41, 2 * BitTime, s);
    hold(1'b1, 8);
    total++; if (fe_count !== 1) $display("[TB] FAIL fe_pulses got %0d want 1", fe_count); else passed++;
    total++; if (wr_addr.size() !== 1) $display("[TB] FAIL fe_writes got %0d want 1", wr_addr.size()); else passed++;
    total++; if (int'(address) !== model_addr) $display("[TB] FAIL fe_addr_held got %0d want %0d", address, model_addr); else passed++;
    clear_queues();
    send_frame(8'h33, 0, s);
    model_frame(8'h33, s);
    hold(1'b1, 4);
    total++; if (wr_addr.size() !== 1) $display("[TB] FAIL fe_recover_count got %0d want 1", wr_addr.size()); else passed++;
    if (wr_addr.size() == 1) begin
      total++; if (int'(wr_addr[0]) !== exp_addr[0]) $display("[TB] FAIL fe_recover_addr got %0d want %0d", wr_addr[0], exp_addr[0]); else passed++;
      total++; if (wr_val[0] !== 7'h33) $display("[TB] FAIL fe_recover_value got %h want 33", wr_val[0]); else passed++;
    end
  endtask

  task automatic test_glitch();
    int s;
    logic [7:0] b;
    clear_queues();
    hold(1'b0, 4);
    hold(1'b1, 8);
    b = rand_non_lf();
    send_frame(b, 0, s);
    model_frame(b, s);
    hold(1'b1, 4);
    total++; if (fe_count !== 0) $display("[TB] FAIL glitch_fe got %0d want 0", fe_count); else passed++;
    total++; if (wr_addr.size() !== 1) $display("[TB] FAIL glitch_writes got %0d want 1", wr_addr.size()); else passed++;
    if (wr_addr.size() == 1) begin
      total++; if (wr_cycle[0] !== exp_cycle[0]) $display("[TB] FAIL glitch_next_cycle got %0d want %0d", wr_cycle[0], exp_cycle[0]); else passed++;
      total++; if (wr_val[0] !== exp_val[0]) $display("[TB] FAIL glitch_next_value got %h want %h", wr_val[0], exp_val[0]); else passed++;
      total++; if (int'(wr_addr[0]) !== exp_addr[0]) $display("[TB] FAIL glitch_next_addr got %0d want %0d", wr_addr[0], exp_addr[0]); else passed++;
    end
  endtask

  task automatic test_back_to_back();
    int s;
    int n;
    logic [7:0] b;
    clear_queues();
    n = $urandom_range(6, 10);
    for (int i = 0; i < n; i++) begin
      b = ($urandom_range(0, 3) == 0) ? 8'h0A : rand_non_lf();
      send_frame(b, 0, s);
      model_frame(b, s);
    end
    hold(1'b1, 4);
    total++; if (wr_addr.size() !== n) $display("[TB] FAIL b2b_count got %0d want %0d", wr_addr.size(), n); else passed++;
    for (int i = 0; i < wr_addr.size() && i < exp_addr.size(); i++) begin
      total++; if (int'(wr_addr[i]) !== exp_addr[i]) $display("[TB] FAIL b2b_addr[%0d] got %0d want %0d", i, wr_addr[i], exp_addr[i]); else passed++;
      total++; if (wr_val[i] !== exp_val[i]) $display("[TB] FAIL b2b_value[%0d] got %h want %h", i, wr_val[i], exp_val[i]); else passed++;
      total++; if (wr_done[i] !== exp_done[i]) $display("[TB] FAIL b2b_done[%0d] got %b want %b", i, wr_done[i], exp_done[i]); else passed++;
      total++; if (wr_cycle[i] !== exp_cycle[i]) $display("[TB] FAIL b2b_cycle[%0d] got %0d want %0d", i, wr_cycle[i], exp_cycle[i]); else passed++;
    end
    total++; if (fe_count !== 0 || stray_done !== 0) $display("[TB] FAIL b2b_spurious got fe=%0d done=%0d want 0", fe_count, stray_done); else passed++;
    total++; if (int'(address) !== model_addr) $display("[TB] FAIL b2b_next_addr got %0d want %0d", address, model_addr); else passed++;
  endtask

  task automatic test_reset_mid_frame();
    int s;
    logic [7:0] b1;
    logic [7:0] b2;
    clear_queues();
    b1 = 8'h20 + 8'($urandom_range(0, 94));
    send_frame(b1, 0, s);
    model_frame(b1, s);
    hold(1'b1, 4);
    b2 = rand_non_lf();
    hold(1'b0, BitTime);
    for (int i = 0; i < 3; i++) hold(b2[i], BitTime);
    hold(b2[3], HalfBit);
    rst_n = 1'b0;
    #1;
    total++; if (read_or_write !== 1'b1) $display("[TB] FAIL midrst_rw got %b want 1", read_or_write); else passed++;
    total++; if (address !== 5'd0) $display("[TB] FAIL midrst_addr got %0d want 0", address); else passed++;
    total++; if (input_value !== 7'd0) $display("[TB] FAIL midrst_value got %h want 0", input_value); else passed++;
    total++; if (message_done !== 1'b0 || framing_error !== 1'b0) $display("[TB] FAIL midrst_pulses got done=%b fe=%b want 0", message_done, framing_error); else passed++;
    serial_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_addr = 0;
    hold(1'b1, 8);
    total++; if (wr_addr.size() !== 1) $display("[TB] FAIL midrst_writes got %0d want 1", wr_addr.size()); else passed++;
    clear_queues();
    send_frame(8'h46, 0, s);
    model_frame(8'h46, s);
    hold(1'b1, 4);
    total++; if (wr_addr.size() !== 1) $display("[TB] FAIL midrst_after_count got %0d want 1", wr_addr.size()); else passed++;
    if (wr_addr.size() == 1) begin
      total++; if (wr_addr[0] !== 5'd0) $display("[TB] FAIL midrst_after_addr got %0d want 0", wr_addr[0]); else passed++;
      total++; if (wr_val[0] !== 7'h46) $display("[TB] FAIL midrst_after_value got %h want 46", wr_val[0]); else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_single_char();
    test_wrap();
    test_line_feed();
    test_framing_error();
    test_glitch();
    test_back_to_back();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
